// File: rtl/seq_carry_propagate_adder.sv
// seq_carry_propagate_adder
// Resolves the redundant sum/carry vector pair from the 4:2 compression tree
// into a single binary result. The pair is added CHUNK bits per cycle, with the
// carry between chunks held in a register. Operands arrive on a valid/ready
// handshake, and the result plus carry-out leave on a second one.

module seq_carry_propagate_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] S1,
   input  logic [WIDTH-1:0] S2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Reject configurations where the chunks would not tile the operand exactly.
   if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("seq_carry_propagate_adder: WIDTH must be a nonzero multiple of CHUNK");
   end

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;

   int unsigned      lsb;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] sum_chunk;
   logic             c_chunk;
   logic             last_chunk;

   // Chunk adder: operand slice for the current index plus the registered carry.
   always_comb begin
      lsb        = int'(idx_q) * CHUNK;
      a_chunk    = a_q[lsb +: CHUNK];
      b_chunk    = b_q[lsb +: CHUNK];
      {c_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      last_chunk = (idx_q == LAST_IDX);
   end

   // Next-state logic for the FSM, the operand capture, and the result assembly.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = S1;
               b_d     = S2;
               carry_d = 1'b0;
               idx_d   = '0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            result_d[lsb +: CHUNK] = sum_chunk;
            carry_d = c_chunk;
            if (last_chunk) begin
               // Park the index at zero so the slice select never leaves the operand.
               idx_d   = '0;
               cout_d  = c_chunk;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State registers; asynchronous reset discards any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

   // Handshake outputs decode the state register only, so they have no input-to-output paths.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      result    = result_q;
      cout      = cout_q;
   end

endmodule

// File: tb/tb_seq_carry_propagate_adder.sv
// Testbench for seq_carry_propagate_adder: default, CHUNK=4 and CHUNK=32 instances
// are checked against a plain 33-bit addition model.

module tb_seq_carry_propagate_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] S1 = '0;
   logic [31:0] S2 = '0;

   logic        in_ready, out_valid, cout;
   logic [31:0] result;
   logic        in_ready4, out_valid4, cout4;
   logic [31:0] result4;
   logic        in_ready32, out_valid32, cout32;
   logic [31:0] result32;

   int total = 0;
   int bad   = 0;

   seq_carry_propagate_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S1(S1), .S2(S2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout));

   seq_carry_propagate_adder #(.WIDTH(32), .CHUNK(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .S1(S1), .S2(S2),
      .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .cout(cout4));

   seq_carry_propagate_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .S1(S1), .S2(S2),
      .out_valid(out_valid32), .out_ready(out_ready), .result(result32), .cout(cout32));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        c;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One transaction on the default instance with out_ready high.
   task automatic do_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input string name);
      int lat;
      bit rdy_low;
      @(negedge clk);
      chk({name, " in_ready before"}, 64'(in_ready), 64'd1);
      S1 = a; S2 = b; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      lat = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) rdy_low = 1'b0;
         // Operands are registered, and in_valid is ignored while busy.
         S1 = $urandom; S2 = $urandom; in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      chk({name, " latency"}, 64'(lat - 1), 64'd4);
      chk({name, " in_ready low while busy"}, 64'(rdy_low), 64'd1);
      chk({name, " result"}, 64'(result), 64'(er));
      chk({name, " cout"}, 64'(cout), 64'(ec));
      @(negedge clk);
      chk({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
      chk({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [32:0] s;
      logic [32:0] expq[$];
      int          acc_cyc[$];
      int          nacc, nres, cyc, lat8, lat4, lat32;
      logic [31:0] pa[3], pb[3], r8, r4, r32, ta, tb;
      logic        c8, c4, c32;
      bit          ok;

      vecs[0] = '{32'h12345678, 32'h0F0F0F0F, 32'h21436587, 1'b0};
      vecs[1] = '{32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
      vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
      vecs[3] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
      vecs[4] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
      vecs[6] = '{32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0};
      for (int i = 7; i < 10; i++) begin
         vecs[i].a = $urandom;
         vecs[i].b = $urandom;
         s = ref_add(vecs[i].a, vecs[i].b);
         vecs[i].r = s[31:0];
         vecs[i].c = s[32];
      end

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset cout", 64'(cout), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_txn(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));
      end

      // Backpressure: hold the result while in_valid toggles with other data.
      @(negedge clk);
      S1 = 32'h80000000; S2 = 32'h80000000; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp reached done", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid; S1 = $urandom; S2 = $urandom;
         @(negedge clk);
         chk($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
         chk($sformatf("bp%0d result", i), 64'(result), 64'd0);
         chk($sformatf("bp%0d cout", i), 64'(cout), 64'd1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp out_valid after release", 64'(out_valid), 64'd0);
      chk("bp in_ready after release", 64'(in_ready), 64'd1);
      chk("bp result kept", 64'(result), 64'd0);
      chk("bp cout kept", 64'(cout), 64'd1);
      @(negedge clk);
      chk("bp no second txn", 64'(in_ready), 64'd1);

      // Back-to-back: in_valid and out_ready held high for three random pairs.
      for (int i = 0; i < 3; i++) begin
         pa[i] = $urandom; pb[i] = $urandom;
      end
      S1 = pa[0]; S2 = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
      nacc = 0; nres = 0; cyc = 0;
      while (nres < 3 && cyc < 60) begin
         if (out_valid) begin
            if (expq.size() > 0) begin
               s = expq.pop_front();
               chk($sformatf("b2b%0d result", nres), {31'd0, cout, result}, 64'(s));
            end else begin
               chk("b2b unexpected output", 64'd1, 64'd0);
            end
            nres++;
         end
         if (in_ready && in_valid) begin
            expq.push_back(ref_add(S1, S2));
            acc_cyc.push_back(cyc);
            nacc++;
         end else if (in_valid && nacc > 0) begin
            if (nacc < 3) begin
               S1 = pa[nacc]; S2 = pb[nacc];
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("b2b results seen", 64'(nres), 64'd3);
      chk("b2b accepts", 64'(acc_cyc.size()), 64'd3);
      if (acc_cyc.size() == 3) begin
         chk("b2b interval1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
         chk("b2b interval2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
      end

      // Asynchronous reset in the middle of ADD.
      @(negedge clk);
      S1 = 32'h11111111; S2 = 32'h22222222; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid partial chunk", 64'(result[7:0]), 64'h33);
      #1 rst = 1'b1;
      #1;
      chk("mid rst out_valid", 64'(out_valid), 64'd0);
      chk("mid rst result", 64'(result), 64'd0);
      chk("mid rst cout", 64'(cout), 64'd0);
      chk("mid rst in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) ok = 1'b0;
      end
      chk("mid no stale output", 64'(ok), 64'd1);
      s = ref_add(32'hDEADBEEF, 32'h3C3C3C3C);
      do_txn(32'hDEADBEEF, 32'h3C3C3C3C, s[31:0], s[32], "after reset");

      // Parameter sweep: the three instances start together from reset.
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         ta = (t == 0) ? 32'hFFFFFFFF : $urandom;
         tb = (t == 0) ? 32'h00000001 : $urandom;
         s = ref_add(ta, tb);
         S1 = ta; S2 = tb; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         lat8 = -1; lat4 = -1; lat32 = -1;
         r8 = '0; r4 = '0; r32 = '0; c8 = 1'b0; c4 = 1'b0; c32 = 1'b0;
         for (int n = 1; n <= 20; n++) begin
            if (out_valid && lat8 < 0) begin lat8 = n - 1; r8 = result; c8 = cout; end
            if (out_valid4 && lat4 < 0) begin lat4 = n - 1; r4 = result4; c4 = cout4; end
            if (out_valid32 && lat32 < 0) begin lat32 = n - 1; r32 = result32; c32 = cout32; end
            @(negedge clk);
         end
         chk($sformatf("sweep%0d lat chunk8", t), 64'(lat8), 64'd4);
         chk($sformatf("sweep%0d lat chunk4", t), 64'(lat4), 64'd8);
         chk($sformatf("sweep%0d lat chunk32", t), 64'(lat32), 64'd1);
         chk($sformatf("sweep%0d sum chunk8", t), {31'd0, c8, r8}, 64'(s));
         chk($sformatf("sweep%0d sum chunk4", t), {31'd0, c4, r4}, 64'(s));
         chk($sformatf("sweep%0d sum chunk32", t), {31'd0, c32, r32}, 64'(s));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
